usb_bit_stuffer_p: RTL and testbench
====================================

# usb_bit_stuffer_p

Parametrised bit-stuff engine for the USB serial path, handling both the transmit and receive sides. It sits between the bit stream encoder and the NRZI encoder on transmit (stuff mode), or between the NRZI decoder and the packet decoder on receive (unstuff mode). The run length is set by a parameter, so the same RTL serves USB (6) and test or other link configurations. In unstuff mode it can also flag stuff errors.

## Interface
- MAX_RUN, 6: consecutive 1s that trigger a stuff or unstuff event; legal range 2..15.
- CNT_W, $clog2(MAX_RUN+1): run counter width.
- MODE, 0: 0 = stuff (TX), 1 = unstuff (RX).

- clk  input  1  clock.
- rst_L  input  1  reset, asynchronous, active-high.
- in_valid  input  1  bit_in valid this cycle.
- bit_in  input  1  serial data bit.
- start  input  1  marks the first bit of a packet; qualified by in_valid.
- last  input  1  marks the final bit of a packet; qualified by in_valid.
- stall  output  1  stuff mode: upstream must hold its bit this cycle. Tied 0 in unstuff mode.
- out_valid  output  1  bit_out valid.
- bit_out  output  1  serial data bit out.
- out_start  output  1  first output bit of the packet.
- out_last  output  1  final output bit of the packet.
- stuff_err  output  1  unstuff mode: one-cycle error pulse (see Configuration).

## Operation
- Input is accepted on a cycle with in_valid=1 and stall=0.
- run_cnt (CNT_W bits) behaviour:
  - Set to bit_in when an accepted bit has start=1.
  - Otherwise incremented on an accepted 1 and cleared on an accepted 0.
  - Saturates at MAX_RUN.
- Stuff mode:
  - Each accepted bit is registered to bit_out with out_valid=1; out_start and out_last are copied from start and last.
  - When run_cnt reaches MAX_RUN, the next cycle is a STUFF cycle:
    - stall=1, and the input is ignored (upstream holds).
    - bit_out=0, out_valid=1, run_cnt cleared.
  - If the accepted bit that reached MAX_RUN carried last=1:
    - out_last is withheld (0) on that bit.
    - out_last is asserted on the following stuffed 0 instead, so a trailing stuff bit is always emitted.
- Unstuff mode:
  - An accepted bit is passed through (out_valid=1) unless run_cnt==MAX_RUN. In that case the bit is dropped (out_valid=0) and run_cnt is cleared.
  - A dropped bit equal to 1 is a stuff error.
  - If a dropped bit carries last=1, out_last=1 is driven with out_valid=0; the consumer treats out_last as an end marker.
- A start=1 bit arriving mid-packet restarts the run count. No stuff bit is pending across it, because in stuff mode the input is held during STUFF.
- Cycles with no accepted input: out_valid=0, out_start=0, out_last=0, and run_cnt is held.

## Timing
- All outputs are registered. stall is decoded from the run_cnt register (run_cnt==MAX_RUN, MODE=0).
- Latency: an accepted bit appears on bit_out one cycle later.
- In stuff mode stall is high for exactly one cycle per stuff event, and never on two consecutive cycles.
- Reset values: out_valid, bit_out, out_start, out_last, stuff_err and stall are all 0; run_cnt is 0.
- Reset mid-packet: outputs drop to 0 asynchronously and any pending STUFF cycle is discarded.
- After reset deassertion the block is ready on the next edge.

## Configuration
- USB_STUFF_ERR_EN:
  - Defined: in unstuff mode, stuff_err pulses for one cycle, one cycle after a dropped bit that was 1 (aligned with where that bit would have appeared on bit_out).
  - Undefined: stuff_err is tied 0 and the erroneous bit is still dropped silently.
  - Stuff mode is unaffected by this macro.

## Test plan
- Stuff, MAX_RUN=6, input 0,1,1,1,1,1,1,1,1 with last on the final bit -> output 0,1,1,1,1,1,1,0,1,1 (10 bits); stall high exactly once, the cycle after the sixth 1; out_last on the final 1.
- Stuff, input 0 followed by six 1s with last on the sixth 1 -> 8 output bits; out_last on the trailing stuffed 0, not on the sixth 1.
- Unstuff, MAX_RUN=6, input 0,1,1,1,1,1,1,0,1,1 -> output 0 followed by eight 1s (9 valid bits); stall stays 0; stuff_err stays 0.
- Unstuff with USB_STUFF_ERR_EN defined, input 0,1,1,1,1,1,1,1 -> the eighth bit is dropped; stuff_err=1 for one cycle; run_cnt cleared.
- MAX_RUN=3 stuff, input of seven 1s -> output 1,1,1,0,1,1,1,0,1 (two stall pulses).
- rst_L asserted during a STUFF cycle -> stall, out_valid and bit_out read 0 immediately; the first bit sent after reset is released produces no stuff bit.

Source files
------------

// File: rtl/usb_bit_stuffer_p.sv
// USB bit stuffer (MODE=0) / unstuffer (MODE=1) with parametrised run length.
// Define USB_STUFF_ERR_EN to enable stuff_err pulses in unstuff mode.
module usb_bit_stuffer_p #(
  parameter int MAX_RUN = 6,
  parameter int CNT_W   = $clog2(MAX_RUN + 1),
  parameter int MODE    = 0
) (
  input  logic clk,
  input  logic rst_L,
  input  logic in_valid,
  input  logic bit_in,
  input  logic start,
  input  logic last,
  output logic stall,
  output logic out_valid,
  output logic bit_out,
  output logic out_start,
  output logic out_last,
  output logic stuff_err
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_nxt;
  logic             pend_last_q, pend_last_d;
  logic             out_valid_q, out_valid_d;
  logic             bit_out_q, bit_out_d;
  logic             out_start_q, out_start_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic             at_max, stuff_cyc, accept;

  assign at_max    = (run_cnt_q == RUN_MAX);
  assign stuff_cyc = (MODE == 0) && at_max;
  assign accept    = in_valid && !stuff_cyc;

  always_comb begin
    run_nxt = '0;
    if (start) begin
      run_nxt = {{(CNT_W-1){1'b0}}, bit_in};
    end else if (bit_in) begin
      run_nxt = at_max ? RUN_MAX : run_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    run_cnt_d   = run_cnt_q;
    pend_last_d = pend_last_q;
    out_valid_d = 1'b0;
    bit_out_d   = 1'b0;
    out_start_d = 1'b0;
    out_last_d  = 1'b0;
    err_d       = 1'b0;
    if (MODE == 0) begin
      if (stuff_cyc) begin
        out_valid_d = 1'b1;
        out_last_d  = pend_last_q;
        pend_last_d = 1'b0;
        run_cnt_d   = '0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        bit_out_d   = bit_in;
        out_start_d = start;
        run_cnt_d   = run_nxt;
        // end marker moves onto the trailing stuff bit
        pend_last_d = last && (run_nxt == RUN_MAX);
        out_last_d  = last && (run_nxt != RUN_MAX);
      end
    end else begin
      pend_last_d = 1'b0;
      if (accept && at_max && !start) begin
        run_cnt_d  = '0;
        out_last_d = last;
`ifdef USB_STUFF_ERR_EN
        err_d      = bit_in;
`endif
      end else if (accept) begin
        out_valid_d = 1'b1;
        bit_out_d   = bit_in;
        out_start_d = start;
        out_last_d  = last;
        run_cnt_d   = run_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_L) begin
    if (rst_L) begin
      run_cnt_q   <= '0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      bit_out_q   <= bit_out_d;
      out_start_q <= out_start_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign stall     = stuff_cyc;
  assign out_valid = out_valid_q;
  assign bit_out   = bit_out_q;
  assign out_start = out_start_q;
  assign out_last  = out_last_q;
  assign stuff_err = err_q;

endmodule

// File: tb/tb_usb_bit_stuffer_p.sv
// Directed bench for usb_bit_stuffer_p: stuff (run 6 and 3) and unstuff (run 6).
`timescale 1ns/1ps
module tb_usb_bit_stuffer_p;

  logic clk = 1'b0;
  logic rst_L = 1'b1;
  logic in_valid = 1'b0;
  logic bit_in = 1'b0;
  logic start = 1'b0;
  logic last = 1'b0;
  int   sel = 0;

  logic tx_st, tx_ov, tx_bo, tx_os, tx_ol, tx_er;
  logic rx_st, rx_ov, rx_bo, rx_os, rx_ol, rx_er;
  logic t3_st, t3_ov, t3_bo, t3_os, t3_ol, t3_er;
  logic o_stall, o_valid, o_bit, o_start, o_last, o_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] obs;
  int obs_n, last_pos, last_nv, start_pos;
  int stall_cnt, stall_idx, consec, err_cnt;

  always #5 clk = ~clk;

  usb_bit_stuffer_p #(.MAX_RUN(6), .MODE(0)) u_tx (
    .clk(clk), .rst_L(rst_L), .in_valid(in_valid), .bit_in(bit_in),
    .start(start), .last(last), .stall(tx_st), .out_valid(tx_ov),
    .bit_out(tx_bo), .out_start(tx_os), .out_last(tx_ol), .stuff_err(tx_er));

  usb_bit_stuffer_p #(.MAX_RUN(6), .MODE(1)) u_rx (
    .clk(clk), .rst_L(rst_L), .in_valid(in_valid), .bit_in(bit_in),
    .start(start), .last(last), .stall(rx_st), .out_valid(rx_ov),
    .bit_out(rx_bo), .out_start(rx_os), .out_last(rx_ol), .stuff_err(rx_er));

  usb_bit_stuffer_p #(.MAX_RUN(3), .MODE(0)) u_tx3 (
    .clk(clk), .rst_L(rst_L), .in_valid(in_valid), .bit_in(bit_in),
    .start(start), .last(last), .stall(t3_st), .out_valid(t3_ov),
    .bit_out(t3_bo), .out_start(t3_os), .out_last(t3_ol), .stuff_err(t3_er));

  always_comb begin
    {o_stall, o_valid, o_bit, o_start, o_last, o_err} = 6'b0;
    case (sel)
      0: {o_stall, o_valid, o_bit, o_start, o_last, o_err} =
           {tx_st, tx_ov, tx_bo, tx_os, tx_ol, tx_er};
      1: {o_stall, o_valid, o_bit, o_start, o_last, o_err} =
           {rx_st, rx_ov, rx_bo, rx_os, rx_ol, rx_er};
      default: {o_stall, o_valid, o_bit, o_start, o_last, o_err} =
           {t3_st, t3_ov, t3_bo, t3_os, t3_ol, t3_er};
    endcase
  end

  task automatic do_reset();
    in_valid = 1'b0; bit_in = 1'b0; start = 1'b0; last = 1'b0;
    rst_L = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_L = 1'b0;
  endtask

  // seq is MSB-first: the first bit sent is seq[n-1]
  task automatic run_seq(input logic [31:0] seq, input int n);
    int idx;
    logic held, prev;
    idx = 0; held = 1'b0; prev = 1'b0;
    obs = '0; obs_n = 0; last_pos = -1; last_nv = 0; start_pos = -1;
    stall_cnt = 0; stall_idx = -1; consec = 0; err_cnt = 0;
    for (int c = 0; c < n + 12; c++) begin
      @(negedge clk);
      if (in_valid && !held) idx++;
      if (o_valid) begin
        if (o_start && start_pos < 0) start_pos = obs_n;
        if (o_last) last_pos = obs_n;
        obs = {obs[30:0], o_bit};
        obs_n++;
      end else if (o_last) begin
        last_nv++;
      end
      if (o_err) err_cnt++;
      if (o_stall) begin
        stall_cnt++;
        if (stall_idx < 0) stall_idx = idx;
        if (prev) consec++;
      end
      prev = o_stall;
      held = o_stall;
      if (idx < n) begin
        in_valid = 1'b1; bit_in = seq[n-1-idx];
        start = (idx == 0); last = (idx == n - 1);
      end else begin
        in_valid = 1'b0; bit_in = 1'b0; start = 1'b0; last = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_L = 1'b1;
    #1;
    n_cmp++; if ({tx_st, tx_ov, tx_bo, tx_os, tx_ol, tx_er} !== 6'b0) begin
      n_bad++; $display("FAIL reset_tx: got %b want 000000", {tx_st, tx_ov, tx_bo, tx_os, tx_ol, tx_er}); end
    n_cmp++; if ({rx_st, rx_ov, rx_bo, rx_os, rx_ol, rx_er} !== 6'b0) begin
      n_bad++; $display("FAIL reset_rx: got %b want 000000", {rx_st, rx_ov, rx_bo, rx_os, rx_ol, rx_er}); end
    n_cmp++; if (u_tx.run_cnt_q !== 3'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", u_tx.run_cnt_q); end
    do_reset();
  endtask

  task automatic test_stuff_basic();
    do_reset(); sel = 0;
    run_seq(32'b011111111, 9);
    n_cmp++; if (obs_n != 10) begin n_bad++; $display("FAIL stuff_len: got %0d want 10", obs_n); end
    n_cmp++; if (obs !== 32'b0111111011) begin n_bad++; $display("FAIL stuff_bits: got %b want 0111111011", obs[9:0]); end
    n_cmp++; if (stall_cnt != 1) begin n_bad++; $display("FAIL stuff_stalls: got %0d want 1", stall_cnt); end
    n_cmp++; if (stall_idx != 7) begin n_bad++; $display("FAIL stuff_stall_at: got %0d want 7", stall_idx); end
    n_cmp++; if (last_pos != 9) begin n_bad++; $display("FAIL stuff_last: got %0d want 9", last_pos); end
    n_cmp++; if (start_pos != 0) begin n_bad++; $display("FAIL stuff_start: got %0d want 0", start_pos); end
  endtask

  task automatic test_stuff_trailing();
    do_reset(); sel = 0;
    run_seq(32'b0111111, 7);
    n_cmp++; if (obs_n != 8) begin n_bad++; $display("FAIL trail_len: got %0d want 8", obs_n); end
    n_cmp++; if (obs !== 32'b01111110) begin n_bad++; $display("FAIL trail_bits: got %b want 01111110", obs[7:0]); end
    n_cmp++; if (last_pos != 7) begin n_bad++; $display("FAIL trail_last: got %0d want 7", last_pos); end
  endtask

  task automatic test_unstuff();
    do_reset(); sel = 1;
    run_seq(32'b0111111011, 10);
    n_cmp++; if (obs_n != 9) begin n_bad++; $display("FAIL unst_len: got %0d want 9", obs_n); end
    n_cmp++; if (obs !== 32'b011111111) begin n_bad++; $display("FAIL unst_bits: got %b want 011111111", obs[8:0]); end
    n_cmp++; if (stall_cnt != 0) begin n_bad++; $display("FAIL unst_stall: got %0d want 0", stall_cnt); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL unst_err: got %0d want 0", err_cnt); end
    n_cmp++; if (last_pos != 8) begin n_bad++; $display("FAIL unst_last: got %0d want 8", last_pos); end
  endtask

  task automatic test_unstuff_err();
    int exp_err;
`ifdef USB_STUFF_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset(); sel = 1;
    run_seq(32'b01111111, 8);
    n_cmp++; if (obs_n != 7) begin n_bad++; $display("FAIL err_len: got %0d want 7", obs_n); end
    n_cmp++; if (obs !== 32'b0111111) begin n_bad++; $display("FAIL err_bits: got %b want 0111111", obs[6:0]); end
    n_cmp++; if (err_cnt != exp_err) begin n_bad++; $display("FAIL err_pulse: got %0d want %0d", err_cnt, exp_err); end
    n_cmp++; if (last_nv != 1) begin n_bad++; $display("FAIL err_endmark: got %0d want 1", last_nv); end
    n_cmp++; if (u_rx.run_cnt_q !== 3'd0) begin n_bad++; $display("FAIL err_cnt_clr: got %0d want 0", u_rx.run_cnt_q); end
  endtask

  task automatic test_run3();
    do_reset(); sel = 2;
    run_seq(32'b1111111, 7);
    n_cmp++; if (obs_n != 9) begin n_bad++; $display("FAIL run3_len: got %0d want 9", obs_n); end
    n_cmp++; if (obs !== 32'b111011101) begin n_bad++; $display("FAIL run3_bits: got %b want 111011101", obs[8:0]); end
    n_cmp++; if (stall_cnt != 2) begin n_bad++; $display("FAIL run3_stalls: got %0d want 2", stall_cnt); end
    n_cmp++; if (consec != 0) begin n_bad++; $display("FAIL run3_consec: got %0d want 0", consec); end
    n_cmp++; if (last_pos != 8) begin n_bad++; $display("FAIL run3_last: got %0d want 8", last_pos); end
  endtask

  task automatic test_reset_mid_stuff();
    logic [6:0] seq;
    seq = 7'b0111111;
    do_reset(); sel = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid = 1'b1; bit_in = seq[6-k]; start = (k == 0); last = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_pre: got %b want 1", o_stall); end
    rst_L = 1'b1;
    in_valid = 1'b0; bit_in = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if ({o_stall, o_valid, o_bit} !== 3'b000) begin
      n_bad++; $display("FAIL mid_rst_out: got %b want 000", {o_stall, o_valid, o_bit}); end
    @(negedge clk);
    rst_L = 1'b0;
    run_seq(32'b1, 1);
    n_cmp++; if (obs_n != 1) begin n_bad++; $display("FAIL mid_post_len: got %0d want 1", obs_n); end
    n_cmp++; if (obs !== 32'b1) begin n_bad++; $display("FAIL mid_post_bit: got %b want 1", obs[0]); end
    n_cmp++; if (stall_cnt != 0) begin n_bad++; $display("FAIL mid_post_stall: got %0d want 0", stall_cnt); end
    n_cmp++; if (last_pos != 0) begin n_bad++; $display("FAIL mid_post_last: got %0d want 0", last_pos); end
  endtask

  initial begin
    test_reset();
    test_stuff_basic();
    test_stuff_trailing();
    test_unstuff();
    test_unstuff_err();
    test_run3();
    test_reset_mid_stuff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
